// File: rtl/sysp_icb_arb.sv
// Two-master round-robin ICB arbiter for the system-peripheral slave port; one read in flight.
// Optional read-response watchdog enabled by defining SYSP_ARB_TIMEOUT_EN.
module sysp_icb_arb #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic            m0_icb_cmd_read,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic            m0_icb_rsp_err,
    output logic [DW-1:0]   m0_icb_rsp_rdata,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic            m1_icb_cmd_read,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic            m1_icb_rsp_err,
    output logic [DW-1:0]   m1_icb_rsp_rdata,

    output logic            s_icb_cmd_valid,
    input  logic            s_icb_cmd_ready,
    output logic [AW-1:0]   s_icb_cmd_addr,
    output logic            s_icb_cmd_read,
    output logic [DW-1:0]   s_icb_cmd_wdata,
    output logic [DW/8-1:0] s_icb_cmd_wmask,
    input  logic            s_icb_rsp_valid,
    output logic            s_icb_rsp_ready,
    input  logic            s_icb_rsp_err,
    input  logic [DW-1:0]   s_icb_rsp_rdata,

    output logic            arb_busy
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic          grant;
    logic          timed_out;
    logic          owner_rsp_ready;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;

    // Sole requester wins; on contention the priority pointer decides.
    assign grant = (m0_icb_cmd_valid && m1_icb_cmd_valid) ? prio_q : m1_icb_cmd_valid;

    assign s_icb_cmd_addr  = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read  = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    assign owner_rsp_ready = owner_q ? m1_icb_rsp_ready : m0_icb_rsp_ready;

`ifdef SYSP_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W   = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero while idle so it always starts from zero on entering RD_WAIT; saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timed_out = (state_q == RD_WAIT) && (cnt_q == CNT_MAX) && !s_icb_rsp_valid;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        prio_d           = prio_q;
        owner_d          = owner_q;
        s_icb_cmd_valid  = 1'b0;
        m0_icb_cmd_ready = 1'b0;
        m1_icb_cmd_ready = 1'b0;
        s_icb_rsp_ready  = 1'b1;
        rsp_valid        = 1'b0;
        rsp_err          = 1'b0;
        rsp_rdata        = '0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so nothing is offered to the slave while reset is held.
                s_icb_cmd_valid  = rst_n && (m0_icb_cmd_valid || m1_icb_cmd_valid);
                m0_icb_cmd_ready = rst_n && !grant && s_icb_cmd_ready;
                m1_icb_cmd_ready = rst_n &&  grant && s_icb_cmd_ready;
                if (s_icb_cmd_valid && s_icb_cmd_ready) begin
                    prio_d = ~grant;
                    if (s_icb_cmd_read) begin
                        owner_d = grant;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                s_icb_rsp_ready = owner_rsp_ready;
                if (timed_out) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                end else begin
                    rsp_valid = s_icb_rsp_valid;
                    rsp_err   = s_icb_rsp_err;
                    rsp_rdata = s_icb_rsp_rdata;
                end
                if (rsp_valid && owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
        end
    end

    assign m0_icb_rsp_valid = rsp_valid && !owner_q;
    assign m1_icb_rsp_valid = rsp_valid &&  owner_q;
    assign m0_icb_rsp_err   = rsp_err;
    assign m1_icb_rsp_err   = rsp_err;
    assign m0_icb_rsp_rdata = rsp_rdata;
    assign m1_icb_rsp_rdata = rsp_rdata;

    assign arb_busy = (state_q == RD_WAIT);

endmodule
